// File: rtl/rp_trig_pkg.sv
// Shared constants for the trigger arming block: FSM state encoding,
// trigger-source codes and the channel-code helper used by the decoder.
package rp_trig_pkg;

    localparam int SRC_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } trig_state_e;

    localparam logic [SRC_W-1:0] SRC_NONE  = 5'd0;
    localparam logic [SRC_W-1:0] SRC_SW    = 5'd1;
    localparam logic [SRC_W-1:0] SRC_CH0_P = 5'd2;
    localparam logic [SRC_W-1:0] SRC_CH0_N = 5'd3;
    localparam logic [SRC_W-1:0] SRC_CH1_P = 5'd4;
    localparam logic [SRC_W-1:0] SRC_CH1_N = 5'd5;
    localparam logic [SRC_W-1:0] SRC_EXT_P = 5'd6;
    localparam logic [SRC_W-1:0] SRC_EXT_N = 5'd7;
    localparam logic [SRC_W-1:0] SRC_ASG_P = 5'd8;
    localparam logic [SRC_W-1:0] SRC_ASG_N = 5'd9;
    localparam logic [SRC_W-1:0] SRC_CH2_P = 5'd10;

    // Channels 0/1 sit below the ext/asg codes; channels 2+ continue from 10.
    function automatic logic [SRC_W-1:0] src_ch_code(input int k, input logic fall);
        int code;
        code = (k < 2) ? (int'(SRC_CH0_P) + 2 * k) : (int'(SRC_CH2_P) + 2 * (k - 2));
        return SRC_W'(code + int'(fall));
    endfunction

endpackage

// File: rtl/rp_trig_decode.sv
// Combinational multiplexer selecting the qualifying event pulse for the
// currently loaded trigger source; unknown codes select nothing.
module rp_trig_decode
    import rp_trig_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [SRC_W-1:0] i_src,
    input  logic             i_sw_evt,
    input  logic [NCH-1:0]   i_ch_p,
    input  logic [NCH-1:0]   i_ch_n,
    input  logic             i_ext_p,
    input  logic             i_ext_n,
    input  logic             i_asg_p,
    input  logic             i_asg_n,
    output logic             o_evt
);

    always_comb begin
        o_evt = 1'b0;
        case (i_src)
            SRC_SW:    o_evt = i_sw_evt;
            SRC_EXT_P: o_evt = i_ext_p;
            SRC_EXT_N: o_evt = i_ext_n;
            SRC_ASG_P: o_evt = i_asg_p;
            SRC_ASG_N: o_evt = i_asg_n;
            default: begin
                for (int k = 0; k < NCH; k++) begin
                    if (i_src == src_ch_code(k, 1'b0)) o_evt = i_ch_p[k];
                    if (i_src == src_ch_code(k, 1'b1)) o_evt = i_ch_n[k];
                end
            end
        endcase
    end

endmodule

// File: rtl/rp_trig_arm.sv
// Trigger arming FSM: counts qualifying events from the selected source,
// fires a one-cycle trigger, then holds off before accepting a new arm.
module rp_trig_arm
    import rp_trig_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CNT_W  = 8,
    parameter int HOLD_W = 16
) (
    input  logic              adc_clk_i,
    input  logic              adc_rst_i,
    input  logic              set_trg_new_i,
    input  logic [SRC_W-1:0]  set_trg_src_i,
    input  logic [CNT_W-1:0]  evt_cnt_i,
    input  logic [HOLD_W-1:0] hold_i,
    input  logic              adc_rst_do_i,
    input  logic              adc_dly_do_i,
    input  logic              trig_dis_clr_i,
    input  logic              adc_trig_sw_i,
    input  logic              dly_valp_i,
    input  logic [NCH-1:0]    adc_trig_p_i,
    input  logic [NCH-1:0]    adc_trig_n_i,
    input  logic              ext_trig_p_i,
    input  logic              ext_trig_n_i,
    input  logic              asg_trig_p_i,
    input  logic              asg_trig_n_i,
    output logic              adc_trig_o,
    output logic [CNT_W-1:0]  trg_cnt_o,
    output logic [15:0]       trg_state_o
);

    // All control inputs are single-cycle pulses sampled on the rising edge;
    // there is no backpressure, every output is valid on every cycle.
    trig_state_e       r_state;
    logic [SRC_W-1:0]  r_src;
    logic [SRC_W-1:0]  r_pend_src;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_pend_cnt;
    logic [HOLD_W-1:0] r_hold;
    logic              r_pend;
    logic              r_dis;
    logic              r_sw_latch;
    logic              r_trig;

    logic              w_sw_evt;
    logic              w_evt;
    logic              w_evt_q;
    logic              w_fire;
    logic              w_abort;
    logic [CNT_W-1:0]  w_load_cnt;
    logic [CNT_W-1:0]  w_pnd_cnt;
    logic [SRC_W-1:0]  w_pnd_src;
    trig_state_e       w_load_state;
    trig_state_e       w_pnd_state;
    logic [1:0]        w_state_bits;

    assign w_sw_evt     = r_sw_latch & dly_valp_i;
    assign w_abort      = adc_rst_do_i | adc_dly_do_i;
    assign w_evt_q      = w_evt & ~r_dis & (r_state == ST_ARMED);
    assign w_fire       = w_evt_q & (r_cnt == CNT_W'(1)) & ~w_abort;
    assign w_load_cnt   = (evt_cnt_i == '0) ? CNT_W'(1) : evt_cnt_i;
    assign w_load_state = (set_trg_src_i != SRC_NONE) ? ST_ARMED : ST_IDLE;

    // A load arriving on the expiry cycle supersedes the stored pending one.
    assign w_pnd_src    = set_trg_new_i ? set_trg_src_i : r_pend_src;
    assign w_pnd_cnt    = set_trg_new_i ? w_load_cnt : r_pend_cnt;
    assign w_pnd_state  = (w_pnd_src != SRC_NONE) ? ST_ARMED : ST_IDLE;

    assign w_state_bits = r_state;

    rp_trig_decode #(
        .NCH(NCH)
    ) u_decode (
        .i_src    (r_src),
        .i_sw_evt (w_sw_evt),
        .i_ch_p   (adc_trig_p_i),
        .i_ch_n   (adc_trig_n_i),
        .i_ext_p  (ext_trig_p_i),
        .i_ext_n  (ext_trig_n_i),
        .i_asg_p  (asg_trig_p_i),
        .i_asg_n  (asg_trig_n_i),
        .o_evt    (w_evt)
    );

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            r_state    <= ST_IDLE;
            r_src      <= '0;
            r_pend_src <= '0;
            r_cnt      <= '0;
            r_pend_cnt <= '0;
            r_hold     <= '0;
            r_pend     <= 1'b0;
            r_dis      <= 1'b0;
            r_sw_latch <= 1'b0;
            r_trig     <= 1'b0;
        end else begin
            r_trig     <= w_fire;
            r_sw_latch <= adc_trig_sw_i | (r_sw_latch & ~dly_valp_i);

            if (w_fire) begin
                r_dis <= 1'b1;
            end else if (trig_dis_clr_i) begin
                r_dis <= 1'b0;
            end

            if (w_abort && set_trg_new_i) begin
                r_state <= w_load_state;
                r_src   <= set_trg_src_i;
                r_cnt   <= w_load_cnt;
                r_hold  <= '0;
                r_pend  <= 1'b0;
            end else if (w_abort) begin
                r_state <= ST_IDLE;
                r_src   <= '0;
                r_cnt   <= '0;
                r_hold  <= '0;
                r_pend  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (set_trg_new_i) begin
                            r_state <= w_load_state;
                            r_src   <= set_trg_src_i;
                            r_cnt   <= w_load_cnt;
                        end
                    end
                    ST_ARMED: begin
                        if (w_fire) begin
                            r_state <= ST_HOLDOFF;
                            r_src   <= '0;
                            r_cnt   <= '0;
                            r_hold  <= hold_i;
                            if (set_trg_new_i) begin
                                r_pend     <= 1'b1;
                                r_pend_src <= set_trg_src_i;
                                r_pend_cnt <= w_load_cnt;
                            end
                        end else if (set_trg_new_i) begin
                            r_state <= w_load_state;
                            r_src   <= set_trg_src_i;
                            r_cnt   <= w_load_cnt;
                        end else if (w_evt_q) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_HOLDOFF: begin
                        if (r_hold == '0) begin
                            r_pend <= 1'b0;
                            if (set_trg_new_i || r_pend) begin
                                r_state <= w_pnd_state;
                                r_src   <= w_pnd_src;
                                r_cnt   <= w_pnd_cnt;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_hold <= r_hold - HOLD_W'(1);
                            if (set_trg_new_i) begin
                                r_pend     <= 1'b1;
                                r_pend_src <= set_trg_src_i;
                                r_pend_cnt <= w_load_cnt;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign adc_trig_o  = r_trig;
    assign trg_cnt_o   = r_cnt;
    assign trg_state_o = {7'd0, w_state_bits, r_pend, r_dis, r_src};

endmodule
